// File: rtl/spi_responder.sv
// SPI mode-0 responder: synchronized SPI inputs, one-byte TX holding buffer, RX byte register.
// Define SPI_RESPONDER_OVERRUN_EN to build the sticky rx_overrun detector.
module spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       mosi,
    input  logic       spi_cs,
    output logic       miso,
    output logic       miso_en,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       busy
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] SELECTED = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic                   sck_prev, cs_prev;
    logic                   sck_s, mosi_s, cs_s;
    logic                   sck_rise, sck_fall, cs_fall;

    logic [0:0] state;
    logic [2:0] bit_count;
    logic [7:0] shift_in, shift_out;
    logic [7:0] tx_buf, tx_next;
    logic       tx_full;
    logic       reload, byte_done;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    // Buffer is consumed at selection and at every byte-boundary falling edge.
    assign tx_next   = tx_full ? tx_buf : 8'hFF;
    assign reload    = (state == IDLE) ? cs_fall
                                       : (~cs_s & sck_fall & (bit_count == 3'd0));
    assign byte_done = (state == SELECTED) & ~cs_s & sck_rise & (bit_count == 3'd7);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_count <= '0;
            shift_in  <= '0;
            shift_out <= 8'hFF;
        end else if (state == IDLE) begin
            if (cs_fall) begin
                state     <= SELECTED;
                bit_count <= '0;
                shift_out <= tx_next;
            end
        end else if (cs_s) begin
            state     <= IDLE;
            bit_count <= '0;
        end else begin
            if (sck_rise) begin
                shift_in  <= {shift_in[6:0], mosi_s};
                bit_count <= bit_count + 3'd1;
            end
            if (sck_fall) begin
                shift_out <= (bit_count == 3'd0) ? tx_next : {shift_out[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (reload && tx_full) begin
            tx_full <= 1'b0;
        end else if (tx_load && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (byte_done) begin
            rx_data  <= {shift_in[6:0], mosi_s};
            rx_valid <= 1'b1;
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_RESPONDER_OVERRUN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_overrun <= 1'b0;
        end else if (byte_done && rx_valid && !rx_ack) begin
            rx_overrun <= 1'b1;
        end else if (rx_ack) begin
            rx_overrun <= 1'b0;
        end
    end
`else
    assign rx_overrun = 1'b0;
`endif

    assign miso     = (state == SELECTED) ? shift_out[7] : 1'b1;
    assign miso_en  = ~cs_s;
    assign tx_ready = ~tx_full;
    assign busy     = (state == SELECTED) && (bit_count != 3'd0);

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed scenarios followed by randomized frames
// checked against a byte-level transaction model.
module tb_spi_responder;

    localparam int  SYNC_STAGES = 2;
    localparam time HALF        = 50;

    logic       clock = 1'b0;
    logic       reset, sck, mosi, spi_cs, tx_load, rx_ack;
    logic [7:0] tx_data;
    logic       miso, miso_en, tx_ready, rx_valid, rx_overrun, busy;
    logic [7:0] rx_data;

    int checks   = 0;
    int failures = 0;

    // Byte-level model state
    logic       m_full, m_valid, m_over;
    logic [7:0] m_tx, m_data, m_next;

    spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clock(clock), .reset(reset), .sck(sck), .mosi(mosi), .spi_cs(spi_cs),
        .miso(miso), .miso_en(miso_en), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic take(output logic [7:0] v);
        v      = m_full ? m_tx : 8'hFF;
        m_full = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        @(negedge clock);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clock);
        tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_tx   = v;
        end
        chk("tx_ready_after_load", tx_ready, !m_full);
    endtask

    task automatic ack();
        @(negedge clock);
        rx_ack = 1'b1;
        @(negedge clock);
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_over  = 1'b0;
        end
        chk("rx_valid_after_ack", rx_valid, m_valid);
        chk("rx_overrun_after_ack", rx_overrun, m_over);
    endtask

    task automatic sel();
        spi_cs = 1'b0;
        #HALF;
        take(m_next);
        chk("miso_en_selected", miso_en, 1'b1);
        chk("tx_ready_after_select", tx_ready, !m_full);
    endtask

    task automatic desel();
        spi_cs = 1'b1;
        #(2 * HALF);
        chk("busy_idle", busy, 1'b0);
        chk("miso_idle", miso, 1'b1);
        chk("miso_en_idle", miso_en, 1'b0);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, input bit lat, output logic [7:0] got);
        time t0;
        got = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #HALF;
            got = {got[6:0], miso};
            sck = 1'b1;
            t0  = $time;
            if (lat && i == 7) begin
                repeat (SYNC_STAGES + 2) @(posedge clock);
                #1;
                chk("rx_latency", rx_valid, 1'b1);
                #(t0 + HALF - $time);
            end else begin
                #HALF;
            end
            sck = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, input bit lat);
        logic [7:0] got;
        spi_bits(b, 8, lat, got);
        #HALF;
        chk("miso_byte", got, m_next);
        take(m_next);
`ifdef SPI_RESPONDER_OVERRUN_EN
        m_over = m_over | m_valid;
`endif
        m_valid = 1'b1;
        m_data  = b;
        chk("rx_valid", rx_valid, m_valid);
        chk("rx_data", rx_data, m_data);
        chk("rx_overrun", rx_overrun, m_over);
        chk("tx_ready", tx_ready, !m_full);
        chk("busy_boundary", busy, 1'b0);
    endtask

    task automatic partial(input int n);
        logic [7:0] got, b;
        b = 8'($urandom);
        spi_bits(b, n, 1'b0, got);
        #HALF;
        chk("miso_partial", got, 32'(m_next >> (8 - n)));
        chk("busy_mid_byte", busy, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_valid"}, rx_valid, 1'b0);
        chk({tag, "_rx_data"}, rx_data, 8'h00);
        chk({tag, "_rx_overrun"}, rx_overrun, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_miso"}, miso, 1'b1);
        chk({tag, "_miso_en"}, miso_en, 1'b0);
        chk({tag, "_tx_ready"}, tx_ready, 1'b1);
    endtask

    initial begin
        int nb;
        reset = 1'b1; sck = 1'b0; mosi = 1'b0; spi_cs = 1'b1;
        tx_load = 1'b0; tx_data = '0; rx_ack = 1'b0;
        m_full = 0; m_valid = 0; m_over = 0; m_tx = '0; m_data = '0; m_next = 8'hFF;
        repeat (3) @(negedge clock);
        check_reset_values("reset_held");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_values("reset_released");

        // Preloaded AA while receiving DB; latency of rx_valid measured on this byte
        push(8'hAA);
        sel();
        xfer(8'hDB, 1'b1);
        chk("miso_pattern_aa", m_data == 8'hDB ? 8'hAA : 8'h00, 8'hAA);
        desel();
        ack();

        // Empty buffer returns FF
        sel();
        xfer(8'h11, 1'b0);
        desel();

        // Two bytes without acknowledge
        ack();
        sel();
        xfer(8'h01, 1'b0);
        xfer(8'h02, 1'b0);
        desel();
        ack();

        // Acknowledge with nothing pending
        ack();

        // Fragment discarded, then full byte
        sel();
        partial(3);
        desel();
        chk("fragment_no_valid", rx_valid, 1'b0);
        sel();
        xfer(8'h5A, 1'b0);
        desel();
        ack();

        // Second load while full is ignored
        push(8'h33);
        push(8'h44);
        chk("tx_ready_full", tx_ready, 1'b0);
        sel();
        xfer(8'h66, 1'b0);
        desel();

        // Reset mid-byte with a pending TX byte and an unacknowledged RX byte
        sel();
        push(8'h77);
        partial(5);
        @(negedge clock);
        reset = 1'b1;
        spi_cs = 1'b1;
        sck = 1'b0;
        #1;
        check_reset_values("reset_mid_byte");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        m_full = 0; m_valid = 0; m_over = 0; m_data = '0;
        repeat (4) @(negedge clock);
        check_reset_values("reset_after");
        sel();
        xfer(8'hC3, 1'b0);
        desel();
        ack();

        // Randomized frames
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(1, 0) == 1) push(8'($urandom));
            if ($urandom_range(3, 0) == 0) push(8'($urandom));
            sel();
            nb = $urandom_range(3, 1);
            for (int k = 0; k < nb; k++) begin
                xfer(8'($urandom), 1'b0);
                if ($urandom_range(2, 0) == 0) ack();
                if ($urandom_range(3, 0) == 0) push(8'($urandom));
            end
            if ($urandom_range(3, 0) == 0) partial($urandom_range(7, 1));
            desel();
            if ($urandom_range(1, 0) == 1) ack();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
